// File: rtl/systolic_row_feeder_pkg.sv
// Shared definitions for the systolic row feeder.
// Holds the array geometry, the derived fetch/stream lengths, counter widths
// and the FSM state encoding used by the feeder and its skew sub-module.
package systolic_row_feeder_pkg;

  localparam int DIM          = 2;
  localparam int FETCH_WORDS  = DIM * DIM;
  localparam int STREAM_BEATS = 2 * DIM - 1;

  localparam int CNT_W  = $clog2(FETCH_WORDS);
  localparam int BEAT_W = $clog2(STREAM_BEATS);

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_STREAM = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/systolic_row_feeder_skew_beat_mux.sv
// skew_beat_mux: combinational map from a stream beat index and the four
// operand registers (row-major A00, A01, A10, A11) to the two left-edge lanes.
// Lane r at beat b carries A[r][b-r] when 0 <= b-r < DIM; otherwise the lane is
// invalid and its data is forced to zero.
//   beat_i        beat index being presented (0..STREAM_BEATS-1)
//   op_i          operand registers, index = 2*row + col
//   row0_data_o   lane 0 data      row0_valid_o  lane 0 valid
//   row1_data_o   lane 1 data      row1_valid_o  lane 1 valid
module skew_beat_mux
  import systolic_row_feeder_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [BEAT_W-1:0]                   beat_i,
  input  logic [FETCH_WORDS-1:0][DATA_W-1:0]  op_i,
  output logic [DATA_W-1:0]                   row0_data_o,
  output logic                                row0_valid_o,
  output logic [DATA_W-1:0]                   row1_data_o,
  output logic                                row1_valid_o
);

  always_comb begin
    row0_data_o  = '0;
    row0_valid_o = 1'b0;
    row1_data_o  = '0;
    row1_valid_o = 1'b0;
    case (beat_i)
      BEAT_W'(0): begin
        row0_data_o  = op_i[0];
        row0_valid_o = 1'b1;
      end
      BEAT_W'(1): begin
        row0_data_o  = op_i[1];
        row0_valid_o = 1'b1;
        row1_data_o  = op_i[2];
        row1_valid_o = 1'b1;
      end
      BEAT_W'(2): begin
        row1_data_o  = op_i[3];
        row1_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: fetches a 2x2 operand matrix from the operand RAM and
// streams it, diagonally skewed, into rows 0/1 of the systolic array.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base              one-cycle request (IDLE only) and A[0][0] address
//   ram_en, ram_we, ram_addr RAM read port (ram_we tied low)
//   ram_do                   RAM read data, one cycle after ram_en
//   row0_*/row1_*            skewed lanes to the PE grid
//   out_ready                array accepts the current beat
//   busy, done               activity flag and end-of-operation pulse
//   state_dbg                current FSM state
//
// Handshake: during STREAM a beat is presented (at least one lane valid) and is
// consumed on a rising edge where out_ready=1; while out_ready=0 every lane
// output holds its value. out_ready only steers next-state logic, so there is
// no combinational path from it to any output, and it is ignored outside
// STREAM.
module systolic_row_feeder
  import systolic_row_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_do,
  output logic [DATA_W-1:0]   row0_data,
  output logic                row0_valid,
  output logic [DATA_W-1:0]   row1_data,
  output logic                row1_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [STATE_W-1:0]  state_dbg
);

  logic [STATE_W-1:0]                state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic [ADDR_W-1:0]                 base_q, base_d;
  logic [FETCH_WORDS-1:0][DATA_W-1:0] op_q, op_d;
  logic                              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0]                 ram_addr_q, ram_addr_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [DATA_W-1:0]                 row0_data_q, row0_data_d;
  logic [DATA_W-1:0]                 row1_data_q, row1_data_d;
  logic                              row0_valid_q, row0_valid_d;
  logic                              row1_valid_q, row1_valid_d;

  // Beat that will be loaded into the lane registers on the next load: beat 0
  // when leaving WAIT, otherwise the successor of the beat on display.
  logic [BEAT_W-1:0] mux_beat;
  logic [DATA_W-1:0] mux_row0_data, mux_row1_data;
  logic              mux_row0_valid, mux_row1_valid;
  logic              load_beat;

  assign mux_beat = (state_q == ST_WAIT) ? '0 : beat_q + BEAT_W'(1);

  skew_beat_mux #(.DATA_W(DATA_W)) u_skew (
    .beat_i       (mux_beat),
    .op_i         (op_q),
    .row0_data_o  (mux_row0_data),
    .row0_valid_o (mux_row0_valid),
    .row1_data_o  (mux_row1_data),
    .row1_valid_o (mux_row1_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    base_d       = base_q;
    op_d         = op_q;
    ram_en_d     = ram_en_q;
    ram_addr_d   = ram_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    row0_data_d  = row0_data_q;
    row1_data_d  = row1_data_q;
    row0_valid_d = row0_valid_q;
    row1_valid_d = row1_valid_q;
    load_beat    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          base_d     = base;
          cnt_d      = '0;
          ram_en_d   = 1'b1;
          ram_addr_d = base;
          busy_d     = 1'b1;
        end
      end
      ST_FETCH: begin
        // The word requested in the previous FETCH cycle is on ram_do now.
        if (cnt_q != '0) op_d[cnt_q - CNT_W'(1)] = ram_do;
        if (cnt_q == CNT_W'(FETCH_WORDS - 1)) begin
          state_d    = ST_WAIT;
          ram_en_d   = 1'b0;
          ram_addr_d = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          // Address arithmetic wraps modulo 2^ADDR_W by truncation.
          ram_addr_d = base_q + ADDR_W'(cnt_d);
        end
      end
      ST_WAIT: begin
        op_d[FETCH_WORDS-1] = ram_do;
        state_d             = ST_STREAM;
        beat_d              = '0;
        load_beat           = 1'b1;
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (beat_q == BEAT_W'(STREAM_BEATS - 1)) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            row0_data_d  = '0;
            row1_data_d  = '0;
            row0_valid_d = 1'b0;
            row1_valid_d = 1'b0;
          end else begin
            beat_d    = beat_q + BEAT_W'(1);
            load_beat = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_beat) begin
      row0_data_d  = mux_row0_data;
      row1_data_d  = mux_row1_data;
      row0_valid_d = mux_row0_valid;
      row1_valid_d = mux_row1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      op_q         <= '0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      row0_data_q  <= '0;
      row1_data_q  <= '0;
      row0_valid_q <= 1'b0;
      row1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      op_q         <= op_d;
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      row0_data_q  <= row0_data_d;
      row1_data_q  <= row1_data_d;
      row0_valid_q <= row0_valid_d;
      row1_valid_q <= row1_valid_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = 1'b0;
  assign ram_addr   = ram_addr_q;
  assign row0_data  = row0_data_q;
  assign row1_data  = row1_data_q;
  assign row0_valid = row0_valid_q;
  assign row1_valid = row1_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: behavioural registered-read RAM, directed
// operations with hand-computed beats, and a negedge monitor that pops the
// expected address, beat and done queues as the DUT presents them.
module tb_systolic_row_feeder;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BW  = 16 + 2 * DW + 2;  // {cycle, v0, d0, v1, d1}
  localparam int AQW = 16 + AW;          // {cycle, addr}

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;
  logic [DW-1:0] row0_data, row1_data;
  logic          row0_valid, row1_valid;
  logic          out_ready;
  logic          busy, done;
  logic [2:0]    state_dbg;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  logic [AQW-1:0] addr_q[$];
  logic [BW-1:0]  exp_q[$];
  logic [15:0]    done_q[$];

  logic [DW-1:0] mem [16];

  systolic_row_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_do     (ram_do),
    .row0_data  (row0_data),
    .row0_valid (row0_valid),
    .row1_data  (row1_data),
    .row1_valid (row1_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand RAM with one-cycle registered read.
  always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

  // ---------------- check helpers ----------------
  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "ram_en"},     64'(ram_en),     64'd0);
    check({p, "ram_addr"},   64'(ram_addr),   64'd0);
    check({p, "ram_we"},     64'(ram_we),     64'd0);
    check({p, "row0_data"},  64'(row0_data),  64'd0);
    check({p, "row1_data"},  64'(row1_data),  64'd0);
    check({p, "row0_valid"}, 64'(row0_valid), 64'd0);
    check({p, "row1_valid"}, 64'(row1_valid), 64'd0);
    check({p, "busy"},       64'(busy),       64'd0);
    check({p, "done"},       64'(done),       64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycle_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_addrs(input int t0, input logic [AW-1:0] b);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = b + AW'(k);
      addr_q.push_back({16'(t0 + 1 + k), a});
    end
  endtask

  // Beats of a run whose start was raised in cycle t0; stall extra cycles on b1.
  task automatic push_beats(input int t0, input logic [DW-1:0] a00, input logic [DW-1:0] a01,
                            input logic [DW-1:0] a10, input logic [DW-1:0] a11,
                            input int stall, input int nb, input bit with_done);
    exp_q.push_back({16'(t0 + 6), 1'b1, a00, 1'b0, DW'(0)});
    if (nb > 1) exp_q.push_back({16'(t0 + 7 + stall), 1'b1, a01, 1'b1, a10});
    if (nb > 2) exp_q.push_back({16'(t0 + 8 + stall), 1'b0, DW'(0), 1'b1, a11});
    if (with_done) done_q.push_back(16'(t0 + 9 + stall));
  endtask

  task automatic issue_start(input logic [AW-1:0] b, output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    t0    = cyc;
    push_addrs(t0, b);
    @(posedge clk); #1;
    start = 1'b0;
    base  = AW'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((addr_q.size() + exp_q.size() + done_q.size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("queues_drained", 64'(addr_q.size() + exp_q.size() + done_q.size()), 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2*DW+1:0] act;
      logic [2*DW+1:0] held;
      logic [BW-1:0]   e;
      check("ram_we", 64'(ram_we), 64'd0);
      if (ram_en) begin
        if (addr_q.size() == 0) check("unexpected_ram_en", 64'(ram_addr), 64'hdead);
        else check("ram_addr", 64'({16'(cyc), ram_addr}), 64'(addr_q.pop_front()));
      end
      if (row0_valid || row1_valid) begin
        act = {row0_valid, row0_data, row1_valid, row1_data};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(act), 64'hdead);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("beat", 64'({16'(cyc), act}), 64'(e));
          check("busy_in_beat", 64'(busy), 64'd1);
        end else begin
          e    = exp_q[0];
          held = e[2*DW+1:0];
          check("beat_hold", 64'(act), 64'(held));
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(cyc), 64'hdead);
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1;
    rst = 1'b1; start = 1'b0; base = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 16'd0; mem[1] = 16'd1; mem[2] = 16'd4; mem[3] = 16'd7;
    mem[4] = 16'd2; mem[5] = 16'd5; mem[6] = 16'd8; mem[7] = 16'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_");
    check("reset_state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // base=1: A = {1,4;7,2}
    issue_start(4'd1, t0);
    push_beats(t0, 16'd1, 16'd4, 16'd7, 16'd2, 0, 3, 1'b1);
    drain();

    // base=4: A = {2,5;8,0}, row1 valid on the zero
    issue_start(4'd4, t0);
    push_beats(t0, 16'd2, 16'd5, 16'd8, 16'd0, 0, 3, 1'b1);
    drain();

    // base=14 wraps: 14,15,0,1 -> A = {9,3;6,1}
    mem[14] = 16'd9; mem[15] = 16'd3; mem[0] = 16'd6; mem[1] = 16'd1;
    issue_start(4'd14, t0);
    push_beats(t0, 16'd9, 16'd3, 16'd6, 16'd1, 0, 3, 1'b1);
    drain();

    // out_ready low in cycles 7..9 while b1 is on display; base=2: A = {4,7;2,5}
    issue_start(4'd2, t0);
    push_beats(t0, 16'd4, 16'd7, 16'd2, 16'd5, 3, 3, 1'b1);
    wait_cycle_to(t0 + 7);
    out_ready = 1'b0;
    wait_cycle_to(t0 + 10);
    out_ready = 1'b1;
    drain();

    // start pulses in cycles 3 and 9 are ignored; base=4: A = {2,5;8,0}
    issue_start(4'd4, t0);
    push_beats(t0, 16'd2, 16'd5, 16'd8, 16'd0, 0, 3, 1'b1);
    wait_cycle_to(t0 + 3);
    start = 1'b1; base = 4'd8;
    wait_cycle_to(t0 + 4);
    start = 1'b0;
    wait_cycle_to(t0 + 9);
    start = 1'b1; base = 4'd8;
    wait_cycle_to(t0 + 10);
    start = 1'b0;
    drain();

    // rst in cycle 7 of a base=14 run, then a fresh base=0 run: A = {6,1;4,7}
    issue_start(4'd14, t0);
    push_beats(t0, 16'd9, 16'd3, 16'd6, 16'd1, 0, 2, 1'b0);
    wait_cycle_to(t0 + 7);
    rst = 1'b1;
    wait_cycle_to(t0 + 8);
    rst   = 1'b0;
    start = 1'b1;
    base  = 4'd0;
    t1    = cyc;
    push_addrs(t1, 4'd0);
    push_beats(t1, 16'd6, 16'd1, 16'd4, 16'd7, 0, 3, 1'b1);
    @(negedge clk);
    check_reset_vals("rst_mid_");
    wait_cycle_to(t1 + 1);
    start = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_row_feeder.md
# systolic_row_feeder

Read-side master for the 16-entry operand RAM of the 2x2 systolic array. On a start pulse it fetches a 2x2 operand matrix (row-major, 4 consecutive words) through the RAM's enable/address port, absorbing the RAM's one-cycle registered read latency. It then streams the rows into the array's left edge with the diagonal skew the PEs need, under a ready/valid handshake. It sits between the operand RAM instance and row inputs 0/1 of the PE grid.

## Interface
- DATA_W, 16, operand width; matches RAM word width
- ADDR_W, 4, RAM address width; 16-word address space
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  ADDR_W  address of A[0][0], sampled with start
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable; constant 0
- ram_addr  out  ADDR_W  RAM address
- ram_do  in  DATA_W  RAM read data, valid the cycle after ram_en
- row0_data, row1_data  out  DATA_W  skewed operand lanes to PE rows 0/1
- row0_valid, row1_valid  out  1  per-lane valid
- out_ready  in  1  array accepts the current beat
- busy  out  1  high from first FETCH cycle to last accepted beat
- done  out  1  one-cycle pulse after the final beat

## Operation
- Matrix layout: A[r][c] at (base + 2r + c) mod 2^ADDR_W. Address wraps silently, e.g. base=14 reads 14, 15, 0, 1.
- States:
  - IDLE: start=1 latches base, goes to FETCH.
  - FETCH: 4 cycles. ram_en=1, ram_addr=base+k for k=0..3. The word for k arrives on ram_do one cycle later and is captured into operand register k.
  - WAIT: 1 cycle. ram_en=0; captures word 3.
  - STREAM: beats b=0..2. A beat advances only when out_ready=1; the beat is held unchanged while out_ready=0.
  - DONE: 1 cycle, done=1, then IDLE.
- Beat contents:
  - b0: row0=A00 valid; row1=0 invalid.
  - b1: row0=A01 valid; row1=A10 valid.
  - b2: row0=0 invalid; row1=A11 valid.
- Any invalid lane drives data 0.
- start outside IDLE is ignored, including in DONE.
- base is not re-sampled mid-operation.
- ram_we is never asserted.
- rst at any cycle: next cycle is IDLE, operand registers cleared, operation abandoned, no done pulse.

## Timing
- Reset values: ram_en=0, ram_addr=0, ram_we=0, row*_data=0, row*_valid=0, busy=0, done=0.
- With start sampled at the end of cycle 0 and out_ready held high:
  - cycles 1–4: FETCH, ram_addr = base..base+3.
  - cycle 5: WAIT.
  - cycles 6, 7, 8: beats b0, b1, b2.
  - cycle 9: done=1, busy=0.
  - cycle 10: IDLE; a new start is accepted.
- Minimum start-to-done latency is 9 cycles. Each cycle with out_ready=0 during STREAM adds one cycle.
- All outputs are registered. No combinational path from out_ready to any output.
- out_ready is ignored outside STREAM.

## Structure
- Shared package holds:
  - state encoding (IDLE, FETCH, WAIT, STREAM, DONE);
  - constants DIM=2, FETCH_WORDS=DIM*DIM, STREAM_BEATS=2*DIM-1.
- One natural sub-module: skew_beat_mux. It is combinational and maps the beat index plus the 4 operand registers to lane data/valid; its outputs are registered in the parent.
- The RAM instance stays outside this block.

## Test plan
- RAM preload {0,1,4,7,2,5,8,0,…}, base=1, out_ready=1: ram_addr 1,2,3,4 in cycles 1–4; beats (1,–), (4,7), (–,2); done in cycle 9.
- Same preload, base=4: A = {2,5;8,0}; beats (2,–), (5,8), (–,0) with row1_valid=1 on the zero.
- base=14 with RAM[14]=9, RAM[15]=3, RAM[0]=6, RAM[1]=1: ram_addr 14,15,0,1 (wrap); beats (9,–), (3,6), (–,1).
- out_ready low for 3 cycles during b1: b1 held stable for 4 cycles; b2 follows; done 3 cycles later (cycle 12).
- start pulsed in cycles 3 and 9 during an operation: both ignored; exactly one done; ram_en pattern unchanged.
- rst asserted in cycle 7 (mid-stream): cycle 8 shows all reset values and no done. A start in cycle 8 begins a fresh fetch in cycle 9 with the new base.
